// File: rtl/scp_pkg.sv
// Shared definitions for the containment sequencer.
// Holds the state encodings, the input classes and the default parameter
// values. Also holds the helper that classifies one cycle's green, yellow
// and red inputs.
package scp_pkg;

   localparam int DEF_TIMER_W       = 6;
   localparam int DEF_NUM_ALARMS    = 3;
   localparam int DEF_YELLOW_LIMIT  = 8;
   localparam int DEF_ALARM_PERIOD  = 4;
   localparam int DEF_CHEAT_CYCLES  = 2;
   localparam int DEF_UNLOCK_CYCLES = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_NORMAL   = 3'd1,
      ST_CAUTION  = 3'd2,
      ST_BREACH   = 3'd3,
      ST_LOCKDOWN = 3'd4,
      ST_CHEAT    = 3'd5
   } scp_state_e;

   typedef enum logic [2:0] {
      IN_QUIET,
      IN_GREEN,
      IN_YELLOW,
      IN_RED,
      IN_MULTI
   } scp_input_e;

   function automatic scp_input_e classify(input logic g, input logic y, input logic r);
      scp_input_e c;
      case ({g, y, r})
         3'b000:  c = IN_QUIET;
         3'b100:  c = IN_GREEN;
         3'b010:  c = IN_YELLOW;
         3'b001:  c = IN_RED;
         default: c = IN_MULTI;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/scp_containment_if.sv
// Bus bundle for the containment sequencer.
//   green/yellow/red : request inputs into the sequencer
//   timer            : cycles spent in the current state (saturating)
//   state            : current state code
//   alarm            : thermometer escalation alarms
//   cheat_out        : sticky illegal-input flag
// The slave modport belongs to the sequencer. The master modport belongs to
// whatever drives the requests.
interface scp_containment_if
   import scp_pkg::*;
#(
   parameter int TIMER_W    = DEF_TIMER_W,
   parameter int NUM_ALARMS = DEF_NUM_ALARMS
);
   logic                  green;
   logic                  yellow;
   logic                  red;
   logic [TIMER_W-1:0]    timer;
   logic [2:0]            state;
   logic [NUM_ALARMS-1:0] alarm;
   logic                  cheat_out;

   modport slave  (input green, yellow, red, output timer, state, alarm, cheat_out);
   modport master (output green, yellow, red, input timer, state, alarm, cheat_out);
endinterface

// File: rtl/scp_alarm_ladder.sv
// Escalation ladder.
// Ports:
//   en_i    : ladder active (next state is BREACH)
//   timer_i : time spent in BREACH
//   alarm_o : thermometer alarms
// alarm_o[k] rises once timer_i >= (k+1)*ALARM_PERIOD-1. The thresholds grow
// with k, so the output is always thermometer coded.
module scp_alarm_ladder
   import scp_pkg::*;
#(
   parameter int TIMER_W      = DEF_TIMER_W,
   parameter int NUM_ALARMS   = DEF_NUM_ALARMS,
   parameter int ALARM_PERIOD = DEF_ALARM_PERIOD
) (
   input  logic                  en_i,
   input  logic [TIMER_W-1:0]    timer_i,
   output logic [NUM_ALARMS-1:0] alarm_o
);
   logic [31:0] timer_ext;

   assign timer_ext = 32'(timer_i);

   always_comb begin
      alarm_o = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         // The thresholds are compared at 32 bits so that a rung beyond the
         // timer range can never fire.
         if (en_i && (timer_ext >= 32'(unsigned'((k + 1) * ALARM_PERIOD - 1))))
            alarm_o[k] = 1'b1;
      end
   end
endmodule

// File: rtl/scp_containment.sv
// Containment sequencer.
// Ports:
//   clock : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of scp_containment_if (requests in, status out)
// Every output is registered. Each one shows the result of the input sample
// taken at the last clock edge.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | no request
// NORMAL   | green only
// CAUTION  | yellow only, counting toward breach
// BREACH   | red seen or yellow held too long; alarms escalate
// LOCKDOWN | all alarms on; a green run of UNLOCK_CYCLES releases
// CHEAT    | repeated multi-colour input; absorbing until reset
module scp_containment
   import scp_pkg::*;
#(
   parameter int TIMER_W       = DEF_TIMER_W,
   parameter int NUM_ALARMS    = DEF_NUM_ALARMS,
   parameter int YELLOW_LIMIT  = DEF_YELLOW_LIMIT,
   parameter int ALARM_PERIOD  = DEF_ALARM_PERIOD,
   parameter int CHEAT_CYCLES  = DEF_CHEAT_CYCLES,
   parameter int UNLOCK_CYCLES = DEF_UNLOCK_CYCLES
) (
   input logic               clock,
   input logic               rst_n,
   scp_containment_if.slave  bus
);
   localparam int MW = (CHEAT_CYCLES  > 1) ? $clog2(CHEAT_CYCLES)  : 1;
   localparam int UW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

   localparam logic [TIMER_W-1:0] TMR_MAX   = '1;
   // The cycle that enters CAUTION counts as the first yellow cycle. The
   // breach therefore fires when the timer moves to YELLOW_LIMIT-1.
   localparam logic [TIMER_W-1:0] YEL_TC    = TIMER_W'(YELLOW_LIMIT - 2);
   localparam logic [MW-1:0]      CHEAT_TC  = MW'(CHEAT_CYCLES - 1);
   localparam logic [UW-1:0]      UNLOCK_TC = UW'(UNLOCK_CYCLES - 1);

   scp_state_e            state_q,  state_d;
   logic [TIMER_W-1:0]    timer_q,  timer_d;
   logic [NUM_ALARMS-1:0] alarm_q,  alarm_d;
   logic                  cheat_q,  cheat_d;
   logic [MW-1:0]         multi_q,  multi_d;
   logic [UW-1:0]         unlock_q, unlock_d;
   logic [NUM_ALARMS-1:0] ladder_alarm;
   scp_input_e            cls;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         alarm_q  <= '0;
         cheat_q  <= 1'b0;
         multi_q  <= '0;
         unlock_q <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         alarm_q  <= alarm_d;
         cheat_q  <= cheat_d;
         multi_q  <= multi_d;
         unlock_q <= unlock_d;
      end
   end

   always_comb begin
      cls      = classify(bus.green, bus.yellow, bus.red);
      state_d  = state_q;
      multi_d  = '0;
      unlock_d = '0;

      if (state_q == ST_CHEAT) begin
         multi_d = multi_q;
      end else if (cls == IN_MULTI) begin
         // A multi-colour cycle below the cheat threshold holds the state.
         if (multi_q == CHEAT_TC) state_d = ST_CHEAT;
         else                     multi_d = multi_q + 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_NORMAL, ST_CAUTION: begin
               case (cls)
                  IN_QUIET:  state_d = ST_IDLE;
                  IN_GREEN:  state_d = ST_NORMAL;
                  IN_YELLOW: state_d = (state_q == ST_CAUTION && timer_q >= YEL_TC)
                                       ? ST_BREACH : ST_CAUTION;
                  IN_RED:    state_d = ST_BREACH;
                  default:   state_d = state_q;
               endcase
            end
            ST_BREACH: begin
               if (alarm_q[NUM_ALARMS-1]) state_d = ST_LOCKDOWN;
            end
            ST_LOCKDOWN: begin
               if (cls == IN_GREEN) begin
                  if (unlock_q == UNLOCK_TC) state_d = ST_NORMAL;
                  else                       unlock_d = unlock_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (state_d != state_q)    timer_d = '0;
      else if (timer_q == TMR_MAX) timer_d = timer_q;
      else                       timer_d = timer_q + 1'b1;
   end

   scp_alarm_ladder #(
      .TIMER_W      (TIMER_W),
      .NUM_ALARMS   (NUM_ALARMS),
      .ALARM_PERIOD (ALARM_PERIOD)
   ) u_ladder (
      .en_i    (state_d == ST_BREACH),
      .timer_i (timer_d),
      .alarm_o (ladder_alarm)
   );

   always_comb begin
      alarm_d = ladder_alarm;
      if (state_d == ST_LOCKDOWN || state_d == ST_CHEAT) alarm_d = '1;
      cheat_d = (state_d == ST_CHEAT);
   end

   assign bus.state     = state_q;
   assign bus.timer     = timer_q;
   assign bus.alarm     = alarm_q;
   assign bus.cheat_out = cheat_q;
endmodule

// File: tb/tb_scp_containment.sv
module tb_scp_containment;
   import scp_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [5:0] tm;
      logic [2:0] al;
      logic       ch;
   } exp_t;

   typedef struct {
      logic g;
      logic y;
      logic r;
      int   n;
      exp_t e;
   } step_t;

   logic clock;
   logic rst_n;
   exp_t sbq[$];
   int   vectors     = 0;
   int   miscompares = 0;

   scp_containment_if #(.TIMER_W(6), .NUM_ALARMS(3)) bus ();

   scp_containment dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t obs();
      exp_t o;
      o = {bus.state, bus.timer, bus.alarm, bus.cheat_out};
      return o;
   endfunction

   function automatic step_t S(input logic g, input logic y, input logic r, input int n,
                               input logic [2:0] st, input logic [5:0] tm,
                               input logic [2:0] al, input logic ch);
      step_t s;
      s.g = g; s.y = y; s.r = r; s.n = n;
      s.e = {st, tm, al, ch};
      return s;
   endfunction

   task automatic drive(input logic g, input logic y, input logic r, input int n);
      bus.green  = g;
      bus.yellow = y;
      bus.red    = r;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      bus.green = 0; bus.yellow = 0; bus.red = 0;
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
   endtask

   task automatic run_steps(input string name, input step_t steps[$]);
      exp_t e, got;
      foreach (steps[i]) begin
         sbq.push_back(steps[i].e);
         drive(steps[i].g, steps[i].y, steps[i].r, steps[i].n);
         got = obs();
         e   = sbq.pop_front();
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL %s step %0d: got st=%0d tm=%0d al=%b ch=%b, want st=%0d tm=%0d al=%b ch=%b",
                     name, i, got.st, got.tm, got.al, got.ch, e.st, e.tm, e.al, e.ch);
         end
      end
   endtask

   task automatic test_reset();
      exp_t e, got;
      step_t st[$];
      do_reset();
      sbq.push_back(exp_t'(0));
      got = obs();
      e   = sbq.pop_front();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", got, e);
      end
      st.push_back(S(0,0,0,3, 3'd0, 6'd3, 3'b000, 0));
      run_steps("idle_quiet", st);
   endtask

   task automatic test_green();
      step_t st[$];
      do_reset();
      st.push_back(S(1,0,0,10, 3'd1, 6'd9,  3'b000, 0));
      st.push_back(S(1,0,0,60, 3'd1, 6'd63, 3'b000, 0));
      st.push_back(S(1,0,0,5,  3'd1, 6'd63, 3'b000, 0));
      run_steps("green", st);
   endtask

   task automatic test_yellow();
      step_t st[$];
      do_reset();
      st.push_back(S(0,1,0,3, 3'd2, 6'd2, 3'b000, 0));
      st.push_back(S(0,0,0,1, 3'd0, 6'd0, 3'b000, 0));
      st.push_back(S(0,1,0,1, 3'd2, 6'd0, 3'b000, 0));
      st.push_back(S(0,1,0,6, 3'd2, 6'd6, 3'b000, 0));
      st.push_back(S(0,1,0,1, 3'd3, 6'd0, 3'b000, 0));
      st.push_back(S(1,0,0,5, 3'd3, 6'd5, 3'b001, 0));
      run_steps("yellow", st);
   endtask

   task automatic test_breach_lockdown();
      step_t st[$];
      do_reset();
      st.push_back(S(0,0,1,1,  3'd3, 6'd0,  3'b000, 0));
      st.push_back(S(0,0,0,2,  3'd3, 6'd2,  3'b000, 0));
      st.push_back(S(0,0,0,1,  3'd3, 6'd3,  3'b001, 0));
      st.push_back(S(0,0,0,4,  3'd3, 6'd7,  3'b011, 0));
      st.push_back(S(0,0,0,4,  3'd3, 6'd11, 3'b111, 0));
      st.push_back(S(0,0,0,1,  3'd4, 6'd0,  3'b111, 0));
      st.push_back(S(1,0,0,15, 3'd4, 6'd15, 3'b111, 0));
      st.push_back(S(0,0,0,1,  3'd4, 6'd16, 3'b111, 0));
      st.push_back(S(1,0,0,15, 3'd4, 6'd31, 3'b111, 0));
      st.push_back(S(1,0,0,1,  3'd1, 6'd0,  3'b000, 0));
      run_steps("breach_lockdown", st);
   endtask

   task automatic test_cheat();
      step_t st[$];
      exp_t e, got;
      do_reset();
      st.push_back(S(1,0,0,3, 3'd1, 6'd2, 3'b000, 0));
      st.push_back(S(1,0,1,1, 3'd1, 6'd3, 3'b000, 0));
      st.push_back(S(1,0,0,1, 3'd1, 6'd4, 3'b000, 0));
      st.push_back(S(1,1,0,1, 3'd1, 6'd5, 3'b000, 0));
      st.push_back(S(1,1,0,1, 3'd5, 6'd0, 3'b111, 1));
      st.push_back(S(0,0,0,5, 3'd5, 6'd5, 3'b111, 1));
      st.push_back(S(1,0,0,1, 3'd5, 6'd6, 3'b111, 1));
      run_steps("cheat", st);
      #2;
      rst_n = 1'b0;
      sbq.push_back(exp_t'(0));
      #1;
      got = obs();
      e   = sbq.pop_front();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL cheat_reset: got %h want %h", got, e);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_breach();
      step_t st[$];
      exp_t e, got;
      do_reset();
      st.push_back(S(0,0,1,1, 3'd3, 6'd0, 3'b000, 0));
      st.push_back(S(0,0,0,5, 3'd3, 6'd5, 3'b001, 0));
      run_steps("pre_reset_breach", st);
      #2;
      rst_n = 1'b0;
      sbq.push_back(exp_t'(0));
      #1;
      got = obs();
      e   = sbq.pop_front();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL async_reset_breach: got %h want %h", got, e);
      end
      do_reset();
      st.delete();
      st.push_back(S(1,0,0,1, 3'd1, 6'd0, 3'b000, 0));
      st.push_back(S(0,1,0,1, 3'd2, 6'd0, 3'b000, 0));
      run_steps("post_reset_resume", st);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.green = 0; bus.yellow = 0; bus.red = 0;
      #3;
      test_reset();
      test_green();
      test_yellow();
      test_breach_lockdown();
      test_cheat();
      test_reset_mid_breach();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/scp_containment.md
SCP_CONTAINMENT -- requirements
Module: scp_containment

Interface
REQ-001 SHALL have parameter TIMER_W, default 6, timer width in bits (legal range 4..16).
REQ-002 SHALL have parameter NUM_ALARMS, default 3, number of escalation alarm outputs (legal range 1..8).
REQ-003 SHALL have parameter YELLOW_LIMIT, default 8, consecutive yellow-only cycles before breach (must be below 2^TIMER_W-1).
REQ-004 SHALL have parameter ALARM_PERIOD, default 4, breach cycles per alarm escalation step.
REQ-005 SHALL have parameter CHEAT_CYCLES, default 2, consecutive multi-input cycles before cheat latch.
REQ-006 SHALL have parameter UNLOCK_CYCLES, default 16, consecutive green-only cycles that release lockdown.
REQ-007 SHALL have one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port green  input  1  containment-nominal request.
REQ-009 SHALL have port yellow  input  1  containment-degraded request.
REQ-010 SHALL have port red  input  1  containment-breach request.
REQ-011 SHALL have port timer  output  TIMER_W  cycles spent in current state, saturating.
REQ-012 SHALL have port state  output  3  current state encoding.
REQ-013 SHALL have port alarm  output  NUM_ALARMS  thermometer-coded escalation alarms.
REQ-014 SHALL have port cheat_out  output  1  sticky illegal-input flag.

Function
REQ-015 SHALL encode states IDLE=0, NORMAL=1, CAUTION=2, BREACH=3, LOCKDOWN=4, CHEAT=5; codes 6-7 unreachable, recover to IDLE next cycle.
REQ-016 SHALL classify each cycle's inputs: none -> quiet; exactly one -> that colour; two or more -> multi.
REQ-017 SHALL count consecutive multi cycles; at CHEAT_CYCLES consecutive, enter CHEAT from any state (highest priority); counter clears on any non-multi cycle.
REQ-018 SHALL, while multi count is below CHEAT_CYCLES, hold current state (multi cycles are otherwise ignored).
REQ-019 SHALL transition from IDLE, NORMAL, CAUTION: quiet -> IDLE, green -> NORMAL, yellow -> CAUTION, red -> BREACH.
REQ-020 SHALL, in CAUTION, enter BREACH when timer reaches YELLOW_LIMIT-1 and yellow remains asserted (breach at the YELLOW_LIMIT-th yellow cycle).
REQ-021 SHALL keep BREACH regardless of green/yellow/quiet; exit only to LOCKDOWN or CHEAT.
REQ-022 SHALL, in BREACH, set alarm[k] once timer >= (k+1)*ALARM_PERIOD-1; alarms are thermometer (alarm[k] implies alarm[k-1]).
REQ-023 SHALL enter LOCKDOWN the cycle after alarm[NUM_ALARMS-1] is set; alarms stay all-ones in LOCKDOWN.
REQ-024 SHALL leave LOCKDOWN to NORMAL after UNLOCK_CYCLES consecutive green-only cycles (separate counter, cleared by any non-green cycle); alarms clear on exit.
REQ-025 SHALL make CHEAT absorbing: cheat_out=1, alarm all-ones, exits only by reset.
REQ-026 SHALL reset timer to 0 on every state change and increment once per cycle otherwise, saturating at 2^TIMER_W-1 (no wrap).
REQ-027 SHALL drive all outputs from registers; state/timer/alarm/cheat_out update on the same edge as the triggering input sample (1-cycle latency).
REQ-028 SHALL keep alarm all-zero in IDLE, NORMAL, CAUTION.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state=IDLE, timer=0, alarm=0, cheat_out=0, all internal counters 0.
REQ-030 SHALL treat reset asserted mid-BREACH, mid-LOCKDOWN or in CHEAT identically (full clear, no retained history).
REQ-031 SHALL resume sampling inputs on the first rising clock edge after rst_n deasserts.

Structure
REQ-032 SHALL place state encodings and default parameter values in shared package scp_pkg.
REQ-033 SHALL implement escalation (alarm thermometer from timer and ALARM_PERIOD) in one sub-module scp_alarm_ladder.
REQ-034 SHALL size internal counters with $clog2 of their limits; no counter may wrap.

Verification (defaults)
REQ-035 SHALL check: green=1 for 10 cycles from reset -> state=1, timer=9, alarm=000, cheat_out=0.
REQ-036 SHALL check: yellow=1 held -> state=2 then state=3 on 8th yellow cycle, timer restarts at 0.
REQ-037 SHALL check: red=1 pulse then quiet -> alarm 001/011/111 after 4/8/12 BREACH cycles, next cycle state=4.
REQ-038 SHALL check: in LOCKDOWN, green=1 for 15 cycles, one quiet cycle, 16 cycles -> state=1 only after the second run, alarm=000.
REQ-039 SHALL check: green=red=1 for 1 cycle -> state unchanged; for 2 cycles -> state=5, cheat_out=1, persists until rst_n low.
REQ-040 SHALL check: green held 70 cycles -> timer saturates at 63; rst_n pulsed low mid-BREACH -> all outputs 0 immediately, without waiting for a clock edge.
